// File: rtl/nway_cache.sv
// nway_cache -- N-way set-associative, write-back, write-allocate cache.
//
// Purpose: sits between a CPU-side bus adaptor (256-bit lines with a 32-bit
// byte-enable) and a cacheline adaptor to physical memory. Replacement uses
// the lowest-index invalid way if there is one, else a per-set tree pseudo-LRU.
// A four-state controller (IDLE, CHECK, WRITEBACK, ALLOCATE) sequences
// lookups, dirty-victim writebacks and line fills.
//
// Optional feature macro: NWAY_CACHE_PERF_CTR_EN
//   defined   -> hit_count / miss_count / wb_count are live 32-bit counters
//   undefined -> counter logic is not built and the outputs are tied to 0
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   mem_address          CPU byte address (offset bits ignored)
//   mem_read, mem_write  CPU request, held until mem_resp
//   mem_byte_enable256   byte-write mask for writes
//   mem_wdata256         CPU write data
//   mem_rdata256         read data, valid with mem_resp
//   mem_resp             one-cycle completion pulse
//   pmem_address         line-aligned memory address
//   pmem_read/pmem_write fill / writeback request, held until pmem_resp
//   pmem_wdata           writeback line
//   pmem_rdata           fill line, valid with pmem_resp
//   pmem_resp            memory completion pulse
//   hit_count, miss_count, wb_count  performance counters
module nway_cache #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int num_ways = 4,
  parameter int s_tag    = 32 - s_offset - s_index,
  parameter int num_sets = 2 ** s_index
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  mem_byte_enable256,
  input  logic [255:0] mem_wdata256,
  output logic [255:0] mem_rdata256,
  output logic         mem_resp,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count,
  output logic [31:0]  wb_count
);

  localparam int s_lru = num_ways - 1;
  localparam int s_way = $clog2(num_ways);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] CHECK     = 2'd1;
  localparam logic [1:0] WRITEBACK = 2'd2;
  localparam logic [1:0] ALLOCATE  = 2'd3;

  // Victim = walk from the root; a node bit of 0 sends the walk to the lower
  // child (2i+1), 1 to the upper child (2i+2). Leaves map to ways in order.
  function automatic logic [s_way-1:0] plru_victim(input logic [s_lru-1:0] tree);
    int node;
    logic [s_lru-1:0] sh;
    node = 0;
    for (int l = 0; l < s_way; l++) begin
      sh   = tree >> node;
      node = 2 * node + 1 + int'(sh[0]);
    end
    return s_way'(node - s_lru);
  endfunction

  // Point every node on the way's path away from it.
  function automatic logic [s_lru-1:0] plru_touch(input logic [s_lru-1:0] tree,
                                                  input logic [s_way-1:0] way);
    int node;
    logic [s_way-1:0] wsh;
    logic [s_lru-1:0] r;
    logic dir;
    r    = tree;
    node = 0;
    for (int l = 0; l < s_way; l++) begin
      wsh  = way >> (s_way - 1 - l);
      dir  = wsh[0];
      r    = (r & ~(s_lru'(1) << node)) | (s_lru'(!dir) << node);
      node = 2 * node + 1 + int'(dir);
    end
    return r;
  endfunction

  logic [1:0]         state_q, state_d;
  logic [s_way-1:0]   victim_q, victim_d;
  logic [s_lru-1:0]   plru_q [num_sets];

  logic [s_index-1:0] set_idx;
  logic [s_tag-1:0]   tag_in;
  logic               unused_offset;

  assign set_idx       = mem_address[s_offset+s_index-1:s_offset];
  assign tag_in        = mem_address[31:s_offset+s_index];
  assign unused_offset = ^mem_address[s_offset-1:0];

  logic [255:0]        way_line [num_ways];
  logic [s_tag-1:0]    way_tag  [num_ways];
  logic [num_ways-1:0] way_valid, way_dirty, hit_vec;
  logic [num_ways-1:0] hit_oh, victim_oh;
  logic [s_way-1:0]    hit_way, inv_way, victim_sel;
  logic                hit, inv_found;
  logic [255:0]        hit_line, merged_line;
  logic                fill_en, write_hit, wb_done;

  assign hit       = |hit_vec;
  assign hit_line  = way_line[hit_way];
  assign hit_oh    = num_ways'(1) << hit_way;
  assign victim_oh = num_ways'(1) << victim_q;
  assign fill_en   = (state_q == ALLOCATE) && pmem_resp;
  assign write_hit = (state_q == CHECK) && hit && mem_write;
  assign wb_done   = (state_q == WRITEBACK) && pmem_resp;

  // Byte merge of CPU write data into the hit line.
  for (genvar gi = 0; gi < 32; gi++) begin : g_merge
    assign merged_line[8*gi +: 8] = mem_byte_enable256[gi] ? mem_wdata256[8*gi +: 8]
                                                           : hit_line[8*gi +: 8];
  end

  // Per-way storage. Data and tag carry no reset; only the state bits do.
  for (genvar gi = 0; gi < num_ways; gi++) begin : g_way
    logic [255:0]        data_q [num_sets];
    logic [s_tag-1:0]    tag_q  [num_sets];
    logic [num_sets-1:0] valid_q, dirty_q;

    always_ff @(posedge clk) begin
      if (fill_en && victim_oh[gi]) begin
        data_q[set_idx] <= pmem_rdata;
        tag_q[set_idx]  <= tag_in;
      end else if (write_hit && hit_oh[gi]) begin
        data_q[set_idx] <= merged_line;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= '0;
        dirty_q <= '0;
      end else if (fill_en && victim_oh[gi]) begin
        valid_q[set_idx] <= 1'b1;
        dirty_q[set_idx] <= 1'b0;
      end else if (wb_done && victim_oh[gi]) begin
        dirty_q[set_idx] <= 1'b0;
      end else if (write_hit && hit_oh[gi]) begin
        dirty_q[set_idx] <= 1'b1;
      end
    end

    assign way_line[gi]  = data_q[set_idx];
    assign way_tag[gi]   = tag_q[set_idx];
    assign way_valid[gi] = valid_q[set_idx];
    assign way_dirty[gi] = dirty_q[set_idx];
    assign hit_vec[gi]   = valid_q[set_idx] && (tag_q[set_idx] == tag_in);
  end

  // Lowest-index match / lowest-index invalid way win.
  always_comb begin
    hit_way   = '0;
    inv_way   = '0;
    inv_found = 1'b0;
    for (int w = num_ways - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = s_way'(w);
      if (!way_valid[w]) begin
        inv_way   = s_way'(w);
        inv_found = 1'b1;
      end
    end
    victim_sel = inv_found ? inv_way : plru_victim(plru_q[set_idx]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < num_sets; s++) plru_q[s] <= '0;
    end else if ((state_q == CHECK) && hit) begin
      plru_q[set_idx] <= plru_touch(plru_q[set_idx], hit_way);
    end else if (fill_en) begin
      plru_q[set_idx] <= plru_touch(plru_q[set_idx], victim_q);
    end
  end

  // Controller: outputs decode straight from state so the async reset
  // drops them immediately.
  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    mem_resp     = 1'b0;
    mem_rdata256 = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) state_d = CHECK;
      end
      CHECK: begin
        if (hit) begin
          mem_resp = 1'b1;
          if (mem_read) mem_rdata256 = hit_line;
          state_d = IDLE;
        end else begin
          victim_d = victim_sel;
          state_d  = (way_valid[victim_sel] && way_dirty[victim_sel]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {way_tag[victim_q], set_idx, {s_offset{1'b0}}};
        pmem_wdata   = way_line[victim_q];
        if (pmem_resp) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = {mem_address[31:s_offset], {s_offset{1'b0}}};
        if (pmem_resp) state_d = CHECK;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

`ifdef NWAY_CACHE_PERF_CTR_EN
  // CHECK re-entered from ALLOCATE is the guaranteed hit after a fill and
  // must not be counted; only a CHECK that follows IDLE is counted.
  logic        from_idle_q;
  logic [31:0] hit_count_q, miss_count_q, wb_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      from_idle_q  <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      wb_count_q   <= '0;
    end else begin
      from_idle_q <= (state_q == IDLE);
      if ((state_q == CHECK) && from_idle_q && hit)  hit_count_q  <= hit_count_q + 32'd1;
      if ((state_q == CHECK) && from_idle_q && !hit) miss_count_q <= miss_count_q + 32'd1;
      if (wb_done)                                   wb_count_q   <= wb_count_q + 32'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
  assign wb_count   = wb_count_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
  assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_nway_cache.sv
module tb_nway_cache;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  mem_address = '0;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [31:0]  mem_byte_enable256 = '0;
  logic [255:0] mem_wdata256 = '0;
  logic [255:0] mem_rdata256;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;
  logic [31:0]  hit_count, miss_count, wb_count;

  nway_cache dut (
    .clk(clk), .rst(rst),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable256(mem_byte_enable256), .mem_wdata256(mem_wdata256),
    .mem_rdata256(mem_rdata256), .mem_resp(mem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

`ifdef NWAY_CACHE_PERF_CTR_EN
  localparam logic [31:0] EXP_HIT = 32'd1, EXP_MISS = 32'd5, EXP_WB = 32'd1;
`else
  localparam logic [31:0] EXP_HIT = 32'd0, EXP_MISS = 32'd0, EXP_WB = 32'd0;
`endif

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Backing memory, golden CPU-visible image, and pmem event log.
  logic [255:0] pmem_store [int unsigned];
  logic [255:0] gold [int unsigned];
  typedef struct { bit is_wr; logic [31:0] addr; logic [255:0] data; } ev_t;
  ev_t ev_q[$];
  typedef struct { bit is_rd; logic [31:0] addr; logic [255:0] data; } sb_t;
  sb_t sb_q[$];

  function automatic logic [255:0] pat(input logic [31:0] a);
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[32*j +: 32] = (a ^ 32'hC0DE_0000) + 32'h0101_0101 * 32'(j);
    return r;
  endfunction

  function automatic logic [255:0] backing(input logic [31:0] a);
    if (pmem_store.exists(a)) return pmem_store[a];
    return pat(a);
  endfunction

  function automatic logic [255:0] gold_line(input logic [31:0] a);
    if (gold.exists(a)) return gold[a];
    return backing(a);
  endfunction

  // Memory responder: pmem_resp after three sampled cycles of a held request.
  int lat_cnt = 0;
  int both_high = 0;
  always @(negedge clk) begin
    pmem_resp = 1'b0;
    if (pmem_read && pmem_write) both_high++;
    if (rst || !(pmem_read || pmem_write)) begin
      lat_cnt = 0;
    end else begin
      lat_cnt++;
      if (lat_cnt == 3) begin
        lat_cnt   = 0;
        pmem_resp = 1'b1;
        if (pmem_write) begin
          pmem_store[pmem_address] = pmem_wdata;
          ev_q.push_back('{1'b1, pmem_address, pmem_wdata});
        end else begin
          pmem_rdata = backing(pmem_address);
          ev_q.push_back('{1'b0, pmem_address, pmem_rdata});
        end
      end
    end
  end

  // Called at a falling edge; returns at a falling edge with the bus idle.
  task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] be,
                        input logic [255:0] wd, input bit exp_hit, input string tag);
    int n_ev, cyc;
    logic [31:0] la, last_addr;
    logic [255:0] line;
    sb_t s;
    la = a & ~32'h1F;
    n_ev = ev_q.size();
    line = gold_line(la);
    if (wr) begin
      for (int b = 0; b < 32; b++) if (be[b]) line[8*b +: 8] = wd[8*b +: 8];
      gold[la] = line;
    end
    sb_q.push_back('{!wr, la, line});
    mem_address = a; mem_read = !wr; mem_write = wr;
    mem_byte_enable256 = be; mem_wdata256 = wd;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!mem_resp && cyc < 300);
    chk({tag, " resp"}, 256'(mem_resp), 256'(1));
    s = sb_q.pop_front();
    if (s.is_rd && mem_resp) chk({tag, " rdata"}, mem_rdata256, s.data);
    if (exp_hit) begin
      chk({tag, " hit latency"}, 256'(cyc), 256'(1));
      chk({tag, " hit pmem events"}, 256'(ev_q.size() - n_ev), 256'(0));
    end else begin
      last_addr = (ev_q.size() > n_ev) ? ev_q[$].addr : 32'hFFFF_FFFF;
      chk({tag, " fill addr"}, 256'(last_addr), 256'(la));
    end
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic sync_reset();
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    gold.delete();
    @(negedge clk);
  endtask

  initial begin
    logic [255:0] ones;
    logic [31:0] be4;
    int n_ev, cyc;
    ones = '1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst mem_resp", 256'(mem_resp), 256'(0));
    chk("rst pmem_read", 256'(pmem_read), 256'(0));
    chk("rst pmem_write", 256'(pmem_write), 256'(0));
    chk("rst mem_rdata", mem_rdata256, 256'(0));
    chk("rst pmem_address", 256'(pmem_address), 256'(0));
    chk("rst pmem_wdata", pmem_wdata, 256'(0));
    chk("rst hit_count", 256'(hit_count), 256'(0));
    #1 rst = 1'b0;
    @(negedge clk);

    // Scenario 1: miss then hit on 0x40
    do_req(0, 32'h40, '0, '0, 0, "s1 read 0x40 miss");
    do_req(0, 32'h44, '0, '0, 1, "s1 read 0x40 hit");

    // Scenario 2: partial write then read back
    be4 = 32'h0000_000F;
    do_req(1, 32'h40, be4, ones, 1, "s2 write 0x40");
    do_req(0, 32'h40, '0, '0, 1, "s2 read 0x40");

    // Scenario 3: fill set 0, replacement picks way 2
    do_req(0, 32'h000, '0, '0, 0, "s3 rd 000");
    do_req(0, 32'h100, '0, '0, 0, "s3 rd 100");
    do_req(0, 32'h200, '0, '0, 0, "s3 rd 200");
    do_req(0, 32'h300, '0, '0, 0, "s3 rd 300");
    do_req(0, 32'h000, '0, '0, 1, "s3 rd 000 again");
    n_ev = ev_q.size();
    do_req(0, 32'h400, '0, '0, 0, "s3 rd 400");
    chk("s3 400 clean victim events", 256'(ev_q.size() - n_ev), 256'(1));
    do_req(0, 32'h200, '0, '0, 0, "s3 rd 200 evicted");
    do_req(0, 32'h000, '0, '0, 1, "s3 rd 000 kept");
    do_req(0, 32'h300, '0, '0, 1, "s3 rd 300 kept");

    // Scenario 4: dirty victim written back before the fill
    sync_reset();
    chk("s4 ctr cleared", 256'(miss_count), 256'(0));
    do_req(0, 32'h000, '0, '0, 0, "s4 rd 000");
    do_req(0, 32'h100, '0, '0, 0, "s4 rd 100");
    do_req(1, 32'h200, 32'h0000_FF00, {8{32'hDEAD_BEEF}}, 0, "s4 wr 200");
    do_req(0, 32'h300, '0, '0, 0, "s4 rd 300");
    do_req(0, 32'h000, '0, '0, 1, "s4 rd 000");
    n_ev = ev_q.size();
    do_req(0, 32'h400, '0, '0, 0, "s4 rd 400");
    chk("s4 event count", 256'(ev_q.size() - n_ev), 256'(2));
    if (ev_q.size() >= n_ev + 2) begin
      chk("s4 wb kind", 256'(ev_q[n_ev].is_wr), 256'(1));
      chk("s4 wb addr", 256'(ev_q[n_ev].addr), 256'(32'h200));
      chk("s4 wb data", ev_q[n_ev].data, gold_line(32'h200));
      chk("s4 fill kind", 256'(ev_q[n_ev+1].is_wr), 256'(0));
      chk("s4 fill addr", 256'(ev_q[n_ev+1].addr), 256'(32'h400));
    end
    chk("s4 hit_count", 256'(hit_count), 256'(EXP_HIT));
    chk("s4 miss_count", 256'(miss_count), 256'(EXP_MISS));
    chk("s4 wb_count", 256'(wb_count), 256'(EXP_WB));
    do_req(0, 32'h200, '0, '0, 0, "s4 rd 200 from memory");

    // Scenario 5: reset during a fill
    mem_address = 32'h60; mem_read = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!pmem_read && cyc < 50);
    chk("s5 pmem_read seen", 256'(pmem_read), 256'(1));
    #1 rst = 1'b1;
    #1;
    chk("s5 pmem_read dropped", 256'(pmem_read), 256'(0));
    chk("s5 pmem_address dropped", 256'(pmem_address), 256'(0));
    chk("s5 no mem_resp", 256'(mem_resp), 256'(0));
    mem_read = 1'b0;
    @(negedge clk);
    chk("s5 no mem_resp held", 256'(mem_resp), 256'(0));
    chk("s5 miss_count cleared", 256'(miss_count), 256'(0));
    #1 rst = 1'b0;
    gold.delete();
    @(negedge clk);
    do_req(0, 32'h40, '0, '0, 0, "s5 rd 0x40 after reset");

    chk("pmem read/write overlap", 256'(both_high), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
